// File: rtl/mux_sel_seq_if.sv
// ---------------------------------------------------------------------------
// mux_sel_seq_if : select-code beat stream between sequencer and operand mux.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mux_sel_seq_if #(
  parameter int LEN_W = 4
);
  logic [1:0]       sel;
  logic             sel_valid;
  logic             sel_ready;
  logic [LEN_W-1:0] step_idx;

  modport master (output sel, output sel_valid, output step_idx, input sel_ready);
  modport slave  (input sel, input sel_valid, input step_idx, output sel_ready);
endinterface

`default_nettype wire

// File: rtl/mux_sel_seq.sv
// ---------------------------------------------------------------------------
// mux_sel_seq : replays a latched 2-bit select pattern for N passes, then done.
// Optional MUX_SEL_SEQ_STALL_CNT_EN adds a saturating stall_cnt output.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_sel_seq #(
  parameter int NUM_STEPS = 8,
  parameter int LEN_W     = 4,
  parameter int REP_W     = 8
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   start,
  input  wire logic                   abort,
  input  wire logic [2*NUM_STEPS-1:0] cfg_pattern,
  input  wire logic [LEN_W-1:0]       cfg_len,
  input  wire logic [REP_W-1:0]       cfg_repeat,
  mux_sel_seq_if.master               bus,
  output logic                        busy,
  output logic                        done
`ifdef MUX_SEL_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(NUM_STEPS);

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [2*NUM_STEPS-1:0] r_pattern;
  logic [LEN_W-1:0]       r_len;
  logic [REP_W-1:0]       r_rep;
  logic [LEN_W-1:0]       r_step;
  logic [REP_W-1:0]       r_pass;
  logic [LEN_W-1:0]       w_len_clamped;
  logic [1:0]             w_sel;
  logic                   w_accept;
  logic                   w_last_step;
  logic                   w_last_pass;

  assign w_len_clamped = (cfg_len > c_max_len) ? c_max_len : cfg_len;
  assign w_accept      = (r_state == S_RUN) && bus.sel_ready;
  assign w_last_step   = (r_step == (r_len - 1'b1));
  assign w_last_pass   = (r_pass == r_rep);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (cfg_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_accept && w_last_step && w_last_pass) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.sel_valid = (r_state == S_RUN);
    busy          = (r_state == S_RUN);
    done          = (r_state == S_DONE);
    bus.sel       = w_sel;
    bus.step_idx  = r_step;
  end

  // Step is left untouched outside RUN so sel keeps its last beat after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= '0;
      r_len     <= '0;
      r_rep     <= '0;
      r_step    <= '0;
      r_pass    <= '0;
    end else if (r_state == S_IDLE) begin
      if (start && (cfg_len != '0)) begin
        r_pattern <= cfg_pattern;
        r_len     <= w_len_clamped;
        r_rep     <= cfg_repeat;
        r_step    <= '0;
        r_pass    <= '0;
      end
    end else if ((r_state == S_RUN) && !abort && w_accept) begin
      if (!w_last_step) begin
        r_step <= r_step + 1'b1;
      end else if (!w_last_pass) begin
        r_step <= '0;
        r_pass <= r_pass + 1'b1;
      end
    end
  end

  always_comb begin
    w_sel = 2'd0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (r_step == LEN_W'(i)) begin
        w_sel = r_pattern[2*i +: 2];
      end
    end
  end

`ifdef MUX_SEL_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_RUN) && !bus.sel_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_seq.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_seq : directed self-checking bench for mux_sel_seq.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mux_sel_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] cfg_pattern;
  logic [3:0]  cfg_len;
  logic [7:0]  cfg_repeat;
  logic        busy;
  logic        done;
`ifdef MUX_SEL_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  mux_sel_seq_if #(.LEN_W(4)) bus ();

  mux_sel_seq #(.NUM_STEPS(8), .LEN_W(4), .REP_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_repeat  (cfg_repeat),
    .bus         (bus),
    .busy        (busy),
    .done        (done)
`ifdef MUX_SEL_SEQ_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; bus.sel_ready = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_repeat = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.sel, bus.sel_valid, bus.step_idx, busy, done} !== 9'd0) begin
      failures++;
      $display("FAIL reset_outputs got sel=%0d v=%0b idx=%0d busy=%0b done=%0b exp all 0",
               bus.sel, bus.sel_valid, bus.step_idx, busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    cfg_pattern = 16'h00E4; cfg_len = 4'd4; cfg_repeat = 8'd0;
    bus.sel_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (bus.sel_valid !== 1'b1 || bus.sel !== 2'd0) begin
      failures++; $display("FAIL rstrun_beat1 got v=%0b sel=%0d exp v=1 sel=0", bus.sel_valid, bus.sel);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.sel !== 2'd2 || bus.step_idx !== 4'd2) begin
      failures++; $display("FAIL rstrun_beat3 got sel=%0d idx=%0d exp sel=2 idx=2", bus.sel, bus.step_idx);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if ({bus.sel, bus.sel_valid, bus.step_idx, busy, done} !== 9'd0) begin
      failures++;
      $display("FAIL rstrun_outputs got sel=%0d v=%0b idx=%0d busy=%0b done=%0b exp all 0",
               bus.sel, bus.sel_valid, bus.step_idx, busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bus.sel_valid !== 1'b0) begin
      failures++; $display("FAIL rstrun_idle got done=%0b v=%0b exp 0 0", done, bus.sel_valid);
    end
  endtask

  task automatic test_single_pass();
    logic [1:0] exp_sel [4] = '{2'd3, 2'd0, 2'd2, 2'd1};
    int busy_cnt = 0;
    cfg_pattern = 16'h0063; cfg_len = 4'd4; cfg_repeat = 8'd0;
    bus.sel_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.sel_valid !== 1'b1 || bus.sel !== exp_sel[i] || done !== 1'b0) begin
        failures++;
        $display("FAIL single_beat%0d got v=%0b sel=%0d done=%0b exp v=1 sel=%0d done=0",
                 i, bus.sel_valid, bus.sel, done, exp_sel[i]);
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || bus.sel_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done got done=%0b v=%0b busy=%0b exp 1 0 0", done, bus.sel_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy_cnt !== 4) begin
      failures++; $display("FAIL single_after got done=%0b busy_cycles=%0d exp done=0 busy_cycles=4", done, busy_cnt);
    end
  endtask

  task automatic test_repeat_stalls();
    int acc = 0;
    int done_cnt = 0;
    logic stalled = 1'b0;
    logic [1:0] prev_sel = 2'd0;
    cfg_pattern = 16'h0039; cfg_len = 4'd3; cfg_repeat = 8'd2;
    bus.sel_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      bus.sel_ready = (cyc % 2 == 0);
      if (done) done_cnt++;
      if (stalled) begin
        checks++;
        if (bus.sel !== prev_sel || bus.sel_valid !== 1'b1) begin
          failures++;
          $display("FAIL rep_stall_hold cyc%0d got sel=%0d v=%0b exp sel=%0d v=1", cyc, bus.sel, bus.sel_valid, prev_sel);
        end
      end
      if (bus.sel_valid && bus.sel_ready) begin
        checks++;
        if (bus.sel !== 2'((acc % 3) + 1)) begin
          failures++; $display("FAIL rep_beat%0d got sel=%0d exp %0d", acc, bus.sel, (acc % 3) + 1);
        end
        acc++;
        stalled = 1'b0;
      end else begin
        stalled = bus.sel_valid;
        prev_sel = bus.sel;
      end
      @(negedge clk);
    end
    bus.sel_ready = 1'b1;
    checks++;
    if (acc !== 9 || done_cnt !== 1) begin
      failures++; $display("FAIL rep_totals got beats=%0d dones=%0d exp beats=9 dones=1", acc, done_cnt);
    end
`ifdef MUX_SEL_SEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd8) begin
      failures++; $display("FAIL rep_stall_cnt got %0d exp 8", stall_cnt);
    end
`endif
  endtask

  task automatic test_len_bounds();
    logic [15:0] pat;
    int acc = 0;
    int done_cnt = 0;
    cfg_pattern = 16'hFFFF; cfg_len = 4'd0; cfg_repeat = 8'd0;
    bus.sel_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (done !== 1'b1 || bus.sel_valid !== 1'b0) begin
      failures++; $display("FAIL zero_len_done got done=%0b v=%0b exp 1 0", done, bus.sel_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bus.sel_valid !== 1'b0) begin
      failures++; $display("FAIL zero_len_after got done=%0b v=%0b exp 0 0", done, bus.sel_valid);
    end
    pat = 16'h1B93;
    cfg_pattern = pat; cfg_len = 4'd12; cfg_repeat = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      int k;
      if (done) done_cnt++;
      if (bus.sel_valid && bus.sel_ready) begin
        k = acc % 8;
        checks++;
        if (bus.step_idx !== 4'(k) || bus.sel !== pat[2*k +: 2]) begin
          failures++;
          $display("FAIL clamp_beat%0d got idx=%0d sel=%0d exp idx=%0d sel=%0d",
                   acc, bus.step_idx, bus.sel, k, pat[2*k +: 2]);
        end
        acc++;
      end
      @(negedge clk);
    end
    checks++;
    if (acc !== 16 || done_cnt !== 1) begin
      failures++; $display("FAIL clamp_totals got beats=%0d dones=%0d exp beats=16 dones=1", acc, done_cnt);
    end
  endtask

  task automatic test_abort_ignored_start();
    cfg_pattern = 16'h00E4; cfg_len = 4'd4; cfg_repeat = 8'd0;
    bus.sel_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.sel !== 2'd1 || bus.step_idx !== 4'd1) begin
      failures++; $display("FAIL abort_beat2 got sel=%0d idx=%0d exp 1 1", bus.sel, bus.step_idx);
    end
    cfg_pattern = 16'h00FF; cfg_len = 4'd2; cfg_repeat = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (bus.sel_valid !== 1'b1 || bus.sel !== 2'd2 || bus.step_idx !== 4'd2) begin
      failures++;
      $display("FAIL ignored_start got v=%0b sel=%0d idx=%0d exp v=1 sel=2 idx=2", bus.sel_valid, bus.sel, bus.step_idx);
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (bus.sel_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL abort_stop got v=%0b busy=%0b done=%0b exp 0 0 0", bus.sel_valid, busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bus.sel_valid !== 1'b0) begin
      failures++; $display("FAIL abort_nodone got done=%0b v=%0b exp 0 0", done, bus.sel_valid);
    end
    cfg_pattern = 16'h0006; cfg_len = 4'd2; cfg_repeat = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (bus.sel_valid !== 1'b1 || bus.sel !== 2'd2 || bus.step_idx !== 4'd0) begin
      failures++;
      $display("FAIL restart_beat1 got v=%0b sel=%0d idx=%0d exp v=1 sel=2 idx=0", bus.sel_valid, bus.sel, bus.step_idx);
    end
    @(negedge clk);
    checks++;
    if (bus.sel !== 2'd1 || bus.step_idx !== 4'd1) begin
      failures++; $display("FAIL restart_beat2 got sel=%0d idx=%0d exp 1 1", bus.sel, bus.step_idx);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL restart_done got done=%0b exp 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    cfg_pattern = 16'h0009; cfg_len = 4'd2; cfg_repeat = 8'd0;
    bus.sel_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.sel_valid !== 1'b1 || bus.sel !== 2'd1) begin
      failures++; $display("FAIL b2b_s1_beat1 got v=%0b sel=%0d exp 1 1", bus.sel_valid, bus.sel);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || bus.sel_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_s1_done got done=%0b v=%0b exp 1 0", done, bus.sel_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bus.sel_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_gap got done=%0b v=%0b busy=%0b exp 0 0 0", done, bus.sel_valid, busy);
    end
    @(negedge clk); start = 1'b0;
    checks++;
    if (bus.sel_valid !== 1'b1 || bus.sel !== 2'd1 || bus.step_idx !== 4'd0) begin
      failures++;
      $display("FAIL b2b_s2_beat1 got v=%0b sel=%0d idx=%0d exp 1 1 0", bus.sel_valid, bus.sel, bus.step_idx);
    end
    @(negedge clk);
    checks++;
    if (bus.sel !== 2'd2) begin
      failures++; $display("FAIL b2b_s2_beat2 got sel=%0d exp 2", bus.sel);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL b2b_s2_done got done=%0b exp 1", done);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.sel_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_no_third got v=%0b busy=%0b exp 0 0", bus.sel_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_single_pass();
    test_repeat_stalls();
    test_len_bounds();
    test_abort_ignored_start();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_sel_seq.md
Name: mux_sel_seq

Overview:
- Programmable select sequencer that sits directly upstream of the 4:1 operand mux.
- Replays a loaded pattern of 2-bit select codes, one code per accepted beat, with a valid/ready handshake to the consumer.
- Repeats the pattern a programmed number of passes, then pulses done.
- Lets the controller drive operand routing for a whole tile with a single start command.

Parameters:
- NUM_STEPS, 8, maximum pattern length (steps per pass); must be >= 2.
- LEN_W, 4, width of cfg_len; must hold values 0..NUM_STEPS.
- REP_W, 8, width of the repeat counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch a sequence; sampled only in IDLE.
- abort  input  1  cancel the sequence in progress.
- cfg_pattern  input  2*NUM_STEPS  step i select is bits [2i+1:2i]; latched on start.
- cfg_len  input  LEN_W  steps per pass; latched on start.
- cfg_repeat  input  REP_W  extra passes (total passes = cfg_repeat+1); latched on start.
- sel  output  2  select code for the mux (drives the mux sel input).
- sel_valid  output  1  sel holds a valid beat.
- sel_ready  input  1  consumer accepts the beat.
- step_idx  output  LEN_W  current step index within the pass.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the final beat is accepted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - sel=0, sel_valid=0, step_idx=0, busy=0, done=0.
  - Latched pattern, length and pass counter are cleared.
  - Reset overrides every other input, including mid-RUN.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and cfg_len in 1..NUM_STEPS: latch pattern, len and repeat; step=0; pass=0; go to RUN.
  - start=1 and cfg_len=0: go to DONE. No beat is issued.
  - start=1 and cfg_len>NUM_STEPS: length is clamped to NUM_STEPS.
- RUN:
  - sel_valid=1 and busy=1.
  - sel = latched pattern[step]; step_idx = step.
  - The first beat is valid the cycle after start is sampled (1-cycle latency).
  - Beat accepted when sel_valid && sel_ready at the clock edge.
  - On accept with step < len-1: step increments; sel updates the next cycle.
  - On accept with step == len-1 and pass < repeat: step=0 and pass increments. No bubble.
  - On accept with step == len-1 and pass == repeat: go to DONE; sel_valid drops the next cycle.
  - sel_ready=0: sel, step_idx and sel_valid hold stable, for unbounded stall.
  - start while in RUN is ignored. Latched config is not affected by cfg_* changes.
- abort:
  - In RUN: go to IDLE next cycle; sel_valid=0, busy=0, no done.
  - abort takes priority over a same-cycle accept; the beat counts as accepted by the consumer, but the sequencer stops.
  - In IDLE or DONE: ignored.
- DONE:
  - done=1 for exactly one cycle; then IDLE.
  - start during DONE is ignored.
  - sel keeps its last value (don't-care to the consumer).
- Back-to-back sequences: minimum gap between a done pulse and the first beat of the next sequence is 2 cycles (DONE → IDLE sample → RUN).
- Counters:
  - pass counter is REP_W wide and compares against the latched repeat; no wrap is possible.
  - step counter is LEN_W wide and resets to 0 at the end of each pass.
- Total accepted beats per sequence = len × (repeat+1). Maximum is NUM_STEPS × 2^REP_W.

Optional Feature:
- Macro: MUX_SEL_SEQ_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (16 bits).
  - Counts cycles in RUN with sel_valid=1 and sel_ready=0.
  - Cleared on rst and on the start sample in IDLE.
  - Saturates at 16'hFFFF.
  - Holds its value after done until the next start.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset mid-RUN:
   - Stimulus: start with len=4, pattern steps {0,1,2,3}, repeat=0, sel_ready=1; assert rst at the 3rd beat.
   - Required: next cycle all outputs are 0 and the state is IDLE; no done pulse.
2. Single pass with constant ready:
   - Stimulus: len=4, pattern steps {3,0,2,1}, repeat=0, sel_ready=1.
   - Required: sel = 3,0,2,1 on 4 consecutive cycles starting 1 cycle after start; done pulses the cycle after the 4th accept; busy covers exactly 4 cycles.
3. Repeat passes with stalls:
   - Stimulus: len=3, pattern steps {1,2,3}, repeat=2; sel_ready toggles 1,0,1,0…
   - Required: accepted sequence is 1,2,3,1,2,3,1,2,3 (9 beats); sel is stable during every stall; exactly one done pulse. With MUX_SEL_SEQ_STALL_CNT_EN defined, stall_cnt=8.
4. Zero and oversize length:
   - Stimulus: start with cfg_len=0.
   - Required: done pulses 1 cycle later; sel_valid is never asserted.
   - Stimulus: start with cfg_len=12 and NUM_STEPS=8.
   - Required: exactly 8 beats per pass.
5. Abort and ignored start:
   - Stimulus: during RUN, pulse start with a different cfg; later pulse abort together with an accept.
   - Required: the new config is ignored; after abort, sel_valid=0 and busy=0 the next cycle, with no done.
   - Stimulus: a fresh start after the abort.
   - Required: the sequence runs from step 0.
6. Back-to-back sequences:
   - Stimulus: start held high continuously, len=2, repeat=0.
   - Required: done, then IDLE, then RUN; the second sequence's first beat appears 2 cycles after the done pulse.
